data_sync: RTL and testbench
============================

Name: data_sync

Overview:
- Destination-domain companion to the team's multi-flop bit synchronizer.
- Transfers a multi-bit bus from a foreign clock domain into CLK using the synchronized-enable method:
  - the 1-bit BUS_EN qualifier passes through an N-flop synchronizer;
  - its rising edge is detected;
  - the stable UNSYNC_BUS is captured on that edge.
- The captured word is presented downstream with a one-cycle ENABLE_PULSE and a VALID/READY holding register.
- Consumers are register-file/ALU control logic in the CLK domain.

Parameters:
- NUM_STAGES, 2, synchronizer depth on BUS_EN; legal values 2..4, elaboration error otherwise.
- BUS_WIDTH, 8, width of the transferred data bus.

Ports:
- CLK  input  1  destination-domain clock.
- RST_n  input  1  reset, asynchronous, active-low.
- UNSYNC_BUS  input  BUS_WIDTH  source-domain data; must be stable while BUS_EN is high.
- BUS_EN  input  1  source-domain level qualifier; rising edge marks a new word.
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
- OVR_CLR  input  1  clears the OVERRUN flag.
- OUT_DATA  output  BUS_WIDTH  captured word (registered).
- OUT_VALID  output  1  OUT_DATA holds an unconsumed word.
- ENABLE_PULSE  output  1  one-cycle strobe in the cycle a new word lands in OUT_DATA.
- OVERRUN  output  1  sticky: a word was overwritten before it was consumed.

Behaviour:
- Reset (async assert, sync release): sync chain, edge register, OUT_DATA, OUT_VALID, ENABLE_PULSE and OVERRUN all 0.
- Sync chain: sync_q[0] <= BUS_EN; sync_q[i] <= sync_q[i-1]. en_s = sync_q[NUM_STAGES-1].
- Edge detect: en_d <= en_s; new_word = en_s & ~en_d (combinational).
- Capture: on the edge where new_word = 1:
  - OUT_DATA <= UNSYNC_BUS;
  - ENABLE_PULSE <= 1 for exactly one cycle;
  - OUT_VALID <= 1.
- Latency: BUS_EN rising before CLK edge 1 gives ENABLE_PULSE and OUT_DATA valid after edge NUM_STAGES+1 (3 edges at the default).
- Falling BUS_EN produces no action.
- Source contract: keep BUS_EN high and UNSYNC_BUS stable for at least NUM_STAGES+2 CLK cycles; keep BUS_EN low for at least NUM_STAGES+1 cycles between words.
- Handshake:
  - A transfer occurs on any edge with OUT_VALID & OUT_READY.
  - OUT_VALID clears on a transfer unless new_word is also 1 that cycle; in that case OUT_VALID stays 1 with the new data and no overrun is flagged.
  - OUT_DATA stays constant while OUT_VALID=1 and no capture occurs.
- Overrun: new_word & OUT_VALID & ~OUT_READY sets OVERRUN and overwrites OUT_DATA (newest word wins).
- OVERRUN clear: OVR_CLR clears OVERRUN. If set and clear occur in the same cycle, set wins.
- OUT_READY while OUT_VALID=0: ignored.
- Reset mid-transfer: all state cleared. If BUS_EN is still high after release, the chain sees a fresh rising edge and a capture occurs NUM_STAGES+1 edges after release (required, not a bug).

Optional Feature:
- Macro DATA_SYNC_ACK_EN adds output BUS_ACK (1 bit, registered, reset 0).
- BUS_ACK sets together with ENABLE_PULSE and clears on the first edge where en_s = 0, giving a four-phase handshake:
  - the source raises BUS_EN;
  - it waits for the synchronized BUS_ACK;
  - it drops BUS_EN;
  - it waits for BUS_ACK to drop.
- With the macro, the hold-time contract is replaced by this handshake.
- Without the macro, the port is absent and the fixed hold/spacing contract above applies.

Decomposition:
- Package cdc_pkg holds MIN_SYNC_STAGES = 2, MAX_SYNC_STAGES = 4 and DEFAULT_SYNC_STAGES = 2, shared with the other CDC blocks.
- One natural sub-module, en_sync_chain: a generic NUM_STAGES-deep single-bit synchronizer with async active-low reset, instantiated for BUS_EN.
- Edge detect, capture and handshake stay in data_sync.

Test Plan:
- Basic transfer (NUM_STAGES=2, OUT_READY=1): UNSYNC_BUS=8'hA5, BUS_EN high for 5 cycles.
  - ENABLE_PULSE is high exactly 1 cycle, after edge 3.
  - OUT_DATA=8'hA5 and OUT_VALID=1 for 1 cycle.
  - OVERRUN=0.
- Backpressure: OUT_READY=0, word 8'h3C delivered; OUT_READY stays 0 for 10 cycles, then goes high.
  - OUT_DATA=8'h3C and OUT_VALID=1 throughout the stall.
  - OUT_VALID drops 1 edge after OUT_READY rises.
- Overrun: OUT_READY=0, words 8'h11 then 8'h22.
  - OUT_DATA=8'h22 and OVERRUN=1.
  - Pulse OVR_CLR: OVERRUN=0.
  - OVR_CLR held on the same cycle as a third overwrite: OVERRUN=1.
- Simultaneous accept and capture: OUT_READY pulsed on the exact capture edge of the second word 8'h77.
  - OUT_VALID stays 1, OUT_DATA=8'h77, OVERRUN=0.
- Reset mid-operation: assert RST_n=0 one cycle before the expected ENABLE_PULSE with BUS_EN held high.
  - All outputs go 0 immediately.
  - After release, ENABLE_PULSE fires NUM_STAGES+1 edges later with the current bus value.
- Depth and option sweep: NUM_STAGES=4 gives capture latency of 5 edges.
  - With DATA_SYNC_ACK_EN defined, BUS_ACK rises with ENABLE_PULSE.
  - BUS_ACK falls NUM_STAGES+1 edges after BUS_EN drops.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared CDC constants: legal synchronizer depths for all CDC blocks.
package cdc_pkg;
  localparam int unsigned MIN_SYNC_STAGES     = 2;
  localparam int unsigned MAX_SYNC_STAGES     = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
endpackage : cdc_pkg

// File: rtl/data_sync_if.sv
// Bus/handshake bundle for data_sync.
// The optional BUS_ACK signal is present only when DATA_SYNC_ACK_EN is defined.
interface data_sync_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic                 BUS_EN;
  logic                 OUT_READY;
  logic                 OVR_CLR;
  logic [BUS_WIDTH-1:0] OUT_DATA;
  logic                 OUT_VALID;
  logic                 ENABLE_PULSE;
  logic                 OVERRUN;
`ifdef DATA_SYNC_ACK_EN
  logic                 BUS_ACK;
`endif

  // Source plus downstream consumer view
  modport master (
    output UNSYNC_BUS, BUS_EN, OUT_READY, OVR_CLR,
`ifdef DATA_SYNC_ACK_EN
    input  BUS_ACK,
`endif
    input  OUT_DATA, OUT_VALID, ENABLE_PULSE, OVERRUN
  );

  // Synchronizer view
  modport slave (
    input  UNSYNC_BUS, BUS_EN, OUT_READY, OVR_CLR,
`ifdef DATA_SYNC_ACK_EN
    output BUS_ACK,
`endif
    output OUT_DATA, OUT_VALID, ENABLE_PULSE, OVERRUN
  );
endinterface : data_sync_if

// File: rtl/en_sync_chain.sv
// Generic NUM_STAGES-deep single-bit synchronizer with async active-low reset.
module en_sync_chain
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [NUM_STAGES-1:0] sync_q;

  // Shift the foreign-domain bit through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[NUM_STAGES-2:0], d};
  end

  assign q = sync_q[NUM_STAGES-1];
endmodule : en_sync_chain

// File: rtl/data_sync.sv
// Synchronized-enable multi-bit bus synchronizer into the CLK domain.
// Optional macro DATA_SYNC_ACK_EN adds the four-phase BUS_ACK return.
module data_sync
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic        CLK,
  input  logic        RST_n,
  data_sync_if.slave  bus
);
  // Reject unsupported synchronizer depths at elaboration
  if (NUM_STAGES < MIN_SYNC_STAGES || NUM_STAGES > MAX_SYNC_STAGES) begin : g_bad_depth
    $error("data_sync: NUM_STAGES must be in 2..4");
  end

  logic                 en_s;
  logic                 en_d;
  logic                 new_word;
  logic [BUS_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 enable_pulse;
  logic                 overrun;

  en_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_en_sync (
    .clk   (CLK),
    .rst_n (RST_n),
    .d     (bus.BUS_EN),
    .q     (en_s)
  );

  // Rising edge of the synchronized qualifier marks a stable new word
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) en_d <= 1'b0;
    else        en_d <= en_s;
  end

  assign new_word = en_s & ~en_d;

  // Capture, strobe and holding-register handshake; newest word always wins
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      out_data     <= '0;
      out_valid    <= 1'b0;
      enable_pulse <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      enable_pulse <= new_word;
      if (new_word) out_data <= bus.UNSYNC_BUS;
      if (new_word)                       out_valid <= 1'b1;
      else if (out_valid && bus.OUT_READY) out_valid <= 1'b0;
      if (new_word && out_valid && !bus.OUT_READY) overrun <= 1'b1;
      else if (bus.OVR_CLR)                        overrun <= 1'b0;
    end
  end

  assign bus.OUT_DATA     = out_data;
  assign bus.OUT_VALID    = out_valid;
  assign bus.ENABLE_PULSE = enable_pulse;
  assign bus.OVERRUN      = overrun;

`ifdef DATA_SYNC_ACK_EN
  logic bus_ack;

  // Acknowledge rises with the capture and drops once the qualifier is seen low
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)        bus_ack <= 1'b0;
    else if (new_word) bus_ack <= 1'b1;
    else if (!en_s)    bus_ack <= 1'b0;
  end

  assign bus.BUS_ACK = bus_ack;
`endif
endmodule : data_sync

// File: tb/tb_data_sync.sv
// Directed self-checking bench for data_sync (default depth plus a depth-4 instance).
module tb_data_sync;
  logic CLK;
  logic RST_n;
  int   checks   = 0;
  int   failures = 0;

  data_sync_if #(.BUS_WIDTH(8)) bus  ();
  data_sync_if #(.BUS_WIDTH(8)) bus4 ();

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) u_dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  data_sync #(.NUM_STAGES(4), .BUS_WIDTH(8)) u_dut4 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    bus.UNSYNC_BUS = 8'h00; bus.BUS_EN = 1'b0; bus.OUT_READY = 1'b0; bus.OVR_CLR = 1'b0;
    bus4.UNSYNC_BUS = 8'h00; bus4.BUS_EN = 1'b0; bus4.OUT_READY = 1'b0; bus4.OVR_CLR = 1'b0;
    tick(3);
    checks++; if (bus.OUT_DATA !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", bus.OUT_DATA); end
    checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.OUT_VALID); end
    checks++; if (bus.ENABLE_PULSE !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b expected 0", bus.ENABLE_PULSE); end
    checks++; if (bus.OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", bus.OVERRUN); end
    RST_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int pulses = 0;
    bus.OUT_READY = 1'b1;
    bus.UNSYNC_BUS = 8'hA5;
    bus.BUS_EN = 1'b1;
    tick(2);
    checks++; if (bus.ENABLE_PULSE !== 1'b0) begin failures++; $display("FAIL basic_early_pulse: got %b expected 0", bus.ENABLE_PULSE); end
    tick(1);
    checks++; if (bus.ENABLE_PULSE !== 1'b1) begin failures++; $display("FAIL basic_pulse: got %b expected 1", bus.ENABLE_PULSE); end
    checks++; if (bus.OUT_DATA !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h expected a5", bus.OUT_DATA); end
    checks++; if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", bus.OUT_VALID); end
    checks++; if (bus.OVERRUN !== 1'b0) begin failures++; $display("FAIL basic_overrun: got %b expected 0", bus.OVERRUN); end
`ifdef DATA_SYNC_ACK_EN
    checks++; if (bus.BUS_ACK !== 1'b1) begin failures++; $display("FAIL basic_ack: got %b expected 1", bus.BUS_ACK); end
`endif
    tick(1);
    checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL basic_valid_drop: got %b expected 0", bus.OUT_VALID); end
    for (int i = 0; i < 6; i++) begin
      if (i == 1) bus.BUS_EN = 1'b0;
      tick(1);
      if (bus.ENABLE_PULSE === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL basic_extra_pulse: got %0d expected 0", pulses); end
  endtask

  task automatic test_backpressure();
    bus.OUT_READY = 1'b0;
    bus.UNSYNC_BUS = 8'h3C;
    bus.BUS_EN = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h3C) begin
        failures++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h expected valid=1 data=3c", i, bus.OUT_VALID, bus.OUT_DATA);
      end
      if (i == 2) bus.BUS_EN = 1'b0;
      tick(1);
    end
    bus.OUT_READY = 1'b1;
    tick(1);
    checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL stall_release: got %b expected 0", bus.OUT_VALID); end
  endtask

  task automatic send(input logic [7:0] d);
    bus.UNSYNC_BUS = d;
    bus.BUS_EN = 1'b1;
    tick(5);
    bus.BUS_EN = 1'b0;
    tick(4);
  endtask

  task automatic test_overrun();
    bus.OUT_READY = 1'b0;
    send(8'h11);
    send(8'h22);
    checks++; if (bus.OUT_DATA !== 8'h22) begin failures++; $display("FAIL ovr_data: got %h expected 22", bus.OUT_DATA); end
    checks++; if (bus.OVERRUN !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", bus.OVERRUN); end
    bus.OVR_CLR = 1'b1;
    tick(1);
    bus.OVR_CLR = 1'b0;
    checks++; if (bus.OVERRUN !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", bus.OVERRUN); end
    bus.UNSYNC_BUS = 8'h33;
    bus.BUS_EN = 1'b1;
    bus.OVR_CLR = 1'b1;
    tick(3);
    bus.OVR_CLR = 1'b0;
    checks++; if (bus.OVERRUN !== 1'b1) begin failures++; $display("FAIL ovr_set_wins: got %b expected 1", bus.OVERRUN); end
    checks++; if (bus.OUT_DATA !== 8'h33) begin failures++; $display("FAIL ovr_third_data: got %h expected 33", bus.OUT_DATA); end
    tick(2);
    bus.BUS_EN = 1'b0;
    bus.OUT_READY = 1'b1;
    bus.OVR_CLR = 1'b1;
    tick(4);
    bus.OVR_CLR = 1'b0;
  endtask

  task automatic test_accept_capture();
    bus.OUT_READY = 1'b0;
    send(8'h66);
    checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h66) begin
      failures++; $display("FAIL ac_first: got valid=%b data=%h expected valid=1 data=66", bus.OUT_VALID, bus.OUT_DATA);
    end
    bus.UNSYNC_BUS = 8'h77;
    bus.BUS_EN = 1'b1;
    tick(2);
    bus.OUT_READY = 1'b1;
    tick(1);
    bus.OUT_READY = 1'b0;
    checks++; if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL ac_valid: got %b expected 1", bus.OUT_VALID); end
    checks++; if (bus.OUT_DATA !== 8'h77) begin failures++; $display("FAIL ac_data: got %h expected 77", bus.OUT_DATA); end
    checks++; if (bus.OVERRUN !== 1'b0) begin failures++; $display("FAIL ac_overrun: got %b expected 0", bus.OVERRUN); end
    tick(1);
    checks++; if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL ac_hold: got %b expected 1", bus.OUT_VALID); end
    tick(1);
    bus.BUS_EN = 1'b0;
    bus.OUT_READY = 1'b1;
    tick(4);
  endtask

  task automatic test_reset_mid();
    bus.OUT_READY = 1'b1;
    bus.UNSYNC_BUS = 8'h5A;
    bus.BUS_EN = 1'b1;
    tick(2);
    RST_n = 1'b0;
    #1;
    checks++; if (bus.OUT_DATA !== 8'h00 || bus.OUT_VALID !== 1'b0 || bus.ENABLE_PULSE !== 1'b0 || bus.OVERRUN !== 1'b0) begin
      failures++; $display("FAIL rst_mid_clear: got data=%h valid=%b pulse=%b ovr=%b expected all 0",
                           bus.OUT_DATA, bus.OUT_VALID, bus.ENABLE_PULSE, bus.OVERRUN);
    end
    tick(1);
    checks++; if (bus.ENABLE_PULSE !== 1'b0) begin failures++; $display("FAIL rst_mid_held: got %b expected 0", bus.ENABLE_PULSE); end
    RST_n = 1'b1;
    bus.UNSYNC_BUS = 8'hC3;
    tick(2);
    checks++; if (bus.ENABLE_PULSE !== 1'b0) begin failures++; $display("FAIL rst_mid_early: got %b expected 0", bus.ENABLE_PULSE); end
    tick(1);
    checks++; if (bus.ENABLE_PULSE !== 1'b1 || bus.OUT_DATA !== 8'hC3) begin
      failures++; $display("FAIL rst_mid_capture: got pulse=%b data=%h expected pulse=1 data=c3", bus.ENABLE_PULSE, bus.OUT_DATA);
    end
    tick(2);
    bus.BUS_EN = 1'b0;
    tick(4);
  endtask

  task automatic test_depth4();
    bus4.OUT_READY = 1'b1;
    bus4.UNSYNC_BUS = 8'h96;
    bus4.BUS_EN = 1'b1;
    tick(4);
    checks++; if (bus4.ENABLE_PULSE !== 1'b0) begin failures++; $display("FAIL d4_early: got %b expected 0", bus4.ENABLE_PULSE); end
    tick(1);
    checks++; if (bus4.ENABLE_PULSE !== 1'b1 || bus4.OUT_DATA !== 8'h96) begin
      failures++; $display("FAIL d4_capture: got pulse=%b data=%h expected pulse=1 data=96", bus4.ENABLE_PULSE, bus4.OUT_DATA);
    end
`ifdef DATA_SYNC_ACK_EN
    checks++; if (bus4.BUS_ACK !== 1'b1) begin failures++; $display("FAIL d4_ack_rise: got %b expected 1", bus4.BUS_ACK); end
`endif
    tick(1);
    bus4.BUS_EN = 1'b0;
    tick(4);
`ifdef DATA_SYNC_ACK_EN
    checks++; if (bus4.BUS_ACK !== 1'b1) begin failures++; $display("FAIL d4_ack_early: got %b expected 1", bus4.BUS_ACK); end
`endif
    tick(1);
`ifdef DATA_SYNC_ACK_EN
    checks++; if (bus4.BUS_ACK !== 1'b0) begin failures++; $display("FAIL d4_ack_fall: got %b expected 0", bus4.BUS_ACK); end
`endif
    checks++; if (bus4.OUT_VALID !== 1'b0) begin failures++; $display("FAIL d4_drained: got %b expected 0", bus4.OUT_VALID); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_accept_capture();
    test_reset_mid();
    test_depth4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule : tb_data_sync
